// File: rtl/demux_reg.sv
// rtl/demux_reg.sv - registered 1:2 valid/ready demultiplexer with per-output transfer counters
module demux_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_select,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic [CNT_WIDTH-1:0] out0_count,
    output logic [CNT_WIDTH-1:0] out1_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state0, state1;
    state_t state0_next, state1_next;

    logic fill0, fill1;
    logic drain0, drain1;
    logic room0, room1;

    // A slot can take a word when it is empty or is being drained this same cycle
    always_comb begin
        room0    = (state0 == EMPTY) || out0_ready;
        room1    = (state1 == EMPTY) || out1_ready;
        in_ready = !reset && (in_select ? room1 : room0);
        fill0    = in_valid && in_ready && !in_select;
        fill1    = in_valid && in_ready && in_select;
        drain0   = (state0 == FULL) && out0_ready;
        drain1   = (state1 == FULL) && out1_ready;
    end

    // Next-state for both holding slots; a same-cycle refill keeps a slot FULL
    always_comb begin
        state0_next = state0;
        state1_next = state1;
        case (state0)
            EMPTY:   if (fill0) state0_next = FULL;
            FULL:    if (drain0 && !fill0) state0_next = EMPTY;
            default: state0_next = EMPTY;
        endcase
        case (state1)
            EMPTY:   if (fill1) state1_next = FULL;
            FULL:    if (drain1 && !fill1) state1_next = EMPTY;
            default: state1_next = EMPTY;
        endcase
    end

    // Slot state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state0 <= EMPTY;
            state1 <= EMPTY;
        end else begin
            state0 <= state0_next;
            state1 <= state1_next;
        end
    end

    // Holding registers only change on an accepted word, so stalled data stays stable
    always_ff @(posedge clk) begin
        if (reset) begin
            out0_data <= '0;
            out1_data <= '0;
        end else begin
            if (fill0) out0_data <= in_data;
            if (fill1) out1_data <= in_data;
        end
    end

    // Completed-transfer counters wrap naturally at 2^CNT_WIDTH
    always_ff @(posedge clk) begin
        if (reset) begin
            out0_count <= '0;
            out1_count <= '0;
        end else begin
            if (drain0) out0_count <= out0_count + 1'b1;
            if (drain1) out1_count <= out1_count + 1'b1;
        end
    end

    assign out0_valid = (state0 == FULL);
    assign out1_valid = (state1 == FULL);

endmodule

// File: tb/tb_demux_reg.sv
// tb/tb_demux_reg.sv - self-checking bench for demux_reg
module tb_demux_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_select;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [31:0] out0_data, out1_data;
    logic [7:0]  out0_count, out1_count;

    logic        reset4, in_valid4, in_select4, in_ready4;
    logic [3:0]  in_data4, out0_data4, out1_data4;
    logic        out0_valid4, out0_ready4, out1_valid4, out1_ready4;
    logic [7:0]  out0_count4, out1_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_reg #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .out0_count(out0_count), .out1_count(out1_count)
    );

    demux_reg #(.WIDTH(4), .CNT_WIDTH(8)) dut4 (
        .clk(clk), .reset(reset4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_select(in_select4), .in_data(in_data4),
        .out0_valid(out0_valid4), .out0_ready(out0_ready4), .out0_data(out0_data4),
        .out1_valid(out1_valid4), .out1_ready(out1_ready4), .out1_data(out1_data4),
        .out0_count(out0_count4), .out1_count(out1_count4)
    );

    // Reference model: each output is a FIFO of capacity one plus a transfer tally
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    int          mcnt0 = 0;
    int          mcnt1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic s, input logic [31:0] d,
                        input logic r0, input logic r1, output logic rdy_seen);
        logic exp_rdy;
        reset = rst; in_valid = v; in_select = s; in_data = d;
        out0_ready = r0; out1_ready = r1;
        #1;
        exp_rdy  = !rst && (s ? (mq1.size() == 0 || r1) : (mq0.size() == 0 || r0));
        rdy_seen = in_ready;
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk); #1;
        if (rst) begin
            mq0.delete(); mq1.delete(); mcnt0 = 0; mcnt1 = 0;
        end else begin
            if (mq0.size() != 0 && r0) begin void'(mq0.pop_front()); mcnt0 = (mcnt0 + 1) % 256; end
            if (mq1.size() != 0 && r1) begin void'(mq1.pop_front()); mcnt1 = (mcnt1 + 1) % 256; end
            if (v && exp_rdy) begin
                if (s) mq1.push_back(d);
                else   mq0.push_back(d);
            end
        end
        chk("out0_valid", out0_valid, mq0.size() != 0);
        chk("out1_valid", out1_valid, mq1.size() != 0);
        if (mq0.size() != 0) chk("out0_data", out0_data, mq0[0]);
        if (mq1.size() != 0) chk("out1_data", out1_data, mq1[0]);
        chk("out0_count", out0_count, mcnt0[7:0]);
        chk("out1_count", out1_count, mcnt1[7:0]);
    endtask

    typedef struct {
        logic        v, s;
        logic [31:0] d;
        logic        r0, r1;
        logic        e_rdy, e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic rdy;
        int   c1_before;

        vecs[0] = '{1'b1, 1'b0, 32'd1234, 1'b1, 1'b1, 1'b1, 1'b1, 32'd1234, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 32'd5678, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0,    1'b1, 32'd5678};
        vecs[2] = '{1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 1'b1, 1'b0, 32'd0,    1'b0, 32'd0};
        vecs[3] = '{1'b1, 1'b0, 32'd10,   1'b0, 1'b1, 1'b1, 1'b1, 32'd10,   1'b0, 32'd0};
        vecs[4] = '{1'b1, 1'b0, 32'd20,   1'b0, 1'b1, 1'b0, 1'b1, 32'd10,   1'b0, 32'd0};
        vecs[5] = '{1'b1, 1'b1, 32'd30,   1'b0, 1'b1, 1'b1, 1'b1, 32'd10,   1'b1, 32'd30};
        vecs[6] = '{1'b1, 1'b0, 32'd20,   1'b1, 1'b1, 1'b1, 1'b1, 32'd20,   1'b0, 32'd0};
        vecs[7] = '{1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 1'b1, 1'b0, 32'd0,    1'b0, 32'd0};

        reset4 = 1'b1; in_valid4 = 1'b0; in_select4 = 1'b0; in_data4 = 4'd0;
        out0_ready4 = 1'b1; out1_ready4 = 1'b1;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rdy);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rdy);
        chk("reset_out0_data", out0_data, 32'd0);
        chk("reset_out1_data", out1_data, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rdy);

        // Routing and stall isolation table
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1, rdy);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, rdy}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_out0_valid", i), {31'd0, out0_valid}, {31'd0, vecs[i].e_v0});
            chk($sformatf("vec%0d_out1_valid", i), {31'd0, out1_valid}, {31'd0, vecs[i].e_v1});
            if (vecs[i].e_v0) chk($sformatf("vec%0d_out0_data", i), out0_data, vecs[i].e_d0);
            if (vecs[i].e_v1) chk($sformatf("vec%0d_out1_data", i), out1_data, vecs[i].e_d1);
            if (i == 2) begin
                chk("route_count0", {24'd0, out0_count}, 32'd1);
                chk("route_count1", {24'd0, out1_count}, 32'd1);
            end
        end

        // Back-to-back to out1
        c1_before = mcnt1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'd100 + i, 1'b1, 1'b1, rdy);
            chk("b2b_accept", {31'd0, rdy}, 32'd1);
            chk("b2b_out1_data", out1_data, 32'd100 + i);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rdy);
        chk("b2b_count", {24'd0, out1_count}, (c1_before + 8) % 256);

        // Counter wrap on out0 from a clean reset
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rdy);
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 1'b0, i, 1'b1, 1'b1, rdy);
        chk("wrap_pre_count0", {24'd0, out0_count}, 32'd255);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rdy);
        chk("wrap_count0", {24'd0, out0_count}, 32'd0);
        chk("wrap_count1", {24'd0, out1_count}, 32'd0);

        // Mid-operation reset with both outputs stalled and full
        step(1'b0, 1'b1, 1'b0, 32'd7, 1'b0, 1'b0, rdy);
        step(1'b0, 1'b1, 1'b1, 32'd9, 1'b0, 1'b0, rdy);
        chk("midrst_full0", {31'd0, out0_valid}, 32'd1);
        chk("midrst_full1", {31'd0, out1_valid}, 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1, rdy);
        chk("midrst_data0", out0_data, 32'd0);
        chk("midrst_data1", out1_data, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, rdy);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, rdy);
        end

        // WIDTH=4 instance routing
        @(posedge clk); #1;
        reset4 = 1'b0; in_valid4 = 1'b1; in_select4 = 1'b0; in_data4 = 4'd5;
        #1 chk("w4_in_ready", {31'd0, in_ready4}, 32'd1);
        @(posedge clk); #1;
        chk("w4_out0_valid", {31'd0, out0_valid4}, 32'd1);
        chk("w4_out0_data", {28'd0, out0_data4}, 32'd5);
        in_select4 = 1'b1; in_data4 = 4'd11;
        @(posedge clk); #1;
        chk("w4_out1_valid", {31'd0, out1_valid4}, 32'd1);
        chk("w4_out1_data", {28'd0, out1_data4}, 32'd11);
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        chk("w4_count0", {24'd0, out0_count4}, 32'd1);
        chk("w4_count1", {24'd0, out1_count4}, 32'd1);
        chk("w4_idle_valid0", {31'd0, out0_valid4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Registered 1:2 demultiplexer with valid/ready handshakes. It routes one input word stream to one of two output channels, chosen per word by a select bit.
- It is the steering counterpart to the 2:1 `mux` used in the datapath. Typical use: routing a write-back or forwarded value to one of two consumers (e.g. register-file write port vs. memory-write path).
- Each output has a one-entry holding register. A stalled consumer blocks only traffic addressed to it.

Parameters:
- WIDTH, 32, data word width in bits (also instantiated at 4).
- CNT_WIDTH, 8, width of each per-output transfer counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word will be accepted this cycle.
- in_select  input  1  destination of the input word: 0 -> out0, 1 -> out1. Sampled only when in_valid=1.
- in_data  input  WIDTH  input word.
- out0_valid  output  1  out0 holds a word.
- out0_ready  input  1  consumer 0 takes the word this cycle.
- out0_data  output  WIDTH  word for consumer 0.
- out1_valid  output  1  out1 holds a word.
- out1_ready  input  1  consumer 1 takes the word this cycle.
- out1_data  output  WIDTH  word for consumer 1.
- out0_count  output  CNT_WIDTH  number of completed out0 transfers.
- out1_count  output  CNT_WIDTH  number of completed out1 transfers.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, out0_count=0, out1_count=0. in_ready=0 while reset=1.
- Per-output state (k = 0, 1): each output is a 2-state machine.
  - EMPTY: outk_valid=0.
  - FULL: outk_valid=1.
- in_ready is combinational, with no dependence on in_valid:
  - in_select=0: in_ready = !reset && (!out0_valid || out0_ready).
  - in_select=1: in_ready = !reset && (!out1_valid || out1_ready).
- Accept: when in_valid && in_ready, in_data is written to the selected holding register. outk_valid=1 from the next cycle. Latency is exactly 1 cycle.
- Drain: when outk_valid && outk_ready, the transfer completes.
  - outk_count increments by 1, wrapping modulo 2^CNT_WIDTH (0xFF -> 0x00 at default).
  - The state returns to EMPTY unless refilled in the same cycle.
- Simultaneous drain and fill of the same output: outk_valid stays 1, outk_data takes the new word, and the count increments. Full throughput is one word per cycle per output.
- Stall: while outk_valid && !outk_ready, outk_data and outk_valid hold stable. Input addressed to k is refused (in_ready=0); input addressed to the other output may still be accepted.
- Independence: a drain on one output never alters the other output's data, valid or count. Both outputs may drain in the same cycle.
- in_valid=0: no state change on the input side; in_select and in_data are don't-care.
- Reset mid-operation: buffered words are discarded and counters cleared on the first clk edge with reset=1, regardless of handshake signals that cycle.
- No combinational path from in_data to outk_data. All outputs except in_ready are registered.

Test Plan:
1. Reset with WIDTH=32 -> all valids 0, data 0, counts 0, in_ready 0. Release reset with out0_ready=out1_ready=1 -> in_ready=1.
2. Routing (WIDTH=32): in_data=1234 with sel=0, then 5678 with sel=1, both consumers ready.
   - out0_data=1234 and out0_valid=1 one cycle after acceptance.
   - out1_data=5678 one cycle after its acceptance.
   - Each count=1.
   - Repeat at WIDTH=4 with 5 and 11.
3. Stall isolation: out0_ready=0, send 10 (sel=0), then 20 (sel=0), then 30 (sel=1).
   - 10 is held on out0.
   - in_ready=0 while 20 is presented.
   - 30 is accepted and appears on out1.
   - Raising out0_ready drains 10, then 20 is accepted.
4. Back-to-back with both readies high: 8 consecutive words to out1 -> one word accepted per cycle, out1_data follows input by 1 cycle, out1_count=8, no bubbles.
5. Counter wrap: 256 transfers on out0 -> out0_count reads 0x00; out1_count unchanged.
6. Mid-operation reset: both outputs FULL (e.g. 7 and 9, consumers stalled), assert reset for one cycle -> valids 0, data 0, counts 0. Stale data never appears afterwards.
